// File: rtl/vgachargen_pkg.sv
// Shared types and constants for the APB front-end of the VGA character generator.
package vgachargen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_WAIT,
    RD_DONE,
    ERR
  } state_e;

  localparam logic [1:0]  CH_REGION    = 2'd0;
  localparam logic [1:0]  COL_REGION   = 2'd1;

  localparam int unsigned CH_WORDS_DEF = 600;
  localparam int unsigned MAP_AW_DEF   = 10;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned STRB_W       = DATA_W / 8;
  localparam int unsigned PADDR_W      = 14;
  localparam int unsigned IDX_W        = 10;

endpackage

// File: rtl/apb_vgachargen_decode.sv
// Combinational APB address decode: region select, word index and range check.
module apb_vgachargen_decode
  import vgachargen_pkg::*;
#(
  parameter int unsigned CH_WORDS = CH_WORDS_DEF
) (
  input  logic [PADDR_W-1:0] paddr_i,
  output logic [1:0]         region_o,
  output logic               region_valid_o,
  output logic [IDX_W-1:0]   index_o,
  output logic               in_range_o
);

  // Accesses are word-wide; the byte-lane bits carry no information here.
  logic [1:0] unused_byte_lane;
  assign unused_byte_lane = paddr_i[1:0];

  assign region_o       = paddr_i[13:12];
  assign region_valid_o = (region_o == CH_REGION) || (region_o == COL_REGION);
  assign index_o        = paddr_i[11:2];
  assign in_range_o     = 32'(index_o) < CH_WORDS;

endmodule

// File: rtl/apb_vgachargen_slave.sv
// APB3 completer for the character and colour maps of the VGA character generator.
// Define APB_VGACHARGEN_PSLVERR_EN to report unmapped/out-of-range accesses on pslverr_o.
module apb_vgachargen_slave
  import vgachargen_pkg::*;
#(
  parameter int unsigned CH_WORDS = CH_WORDS_DEF,
  parameter int unsigned MAP_AW   = MAP_AW_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PADDR_W-1:0]  paddr_i,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic                pwrite_i,
  input  logic [DATA_W-1:0]   pwdata_i,
  input  logic [STRB_W-1:0]   pstrb_i,
  output logic [DATA_W-1:0]   prdata_o,
  output logic                pready_o,
  output logic                pslverr_o,
  output logic [MAP_AW-1:0]   ch_map_addr_o,
  output logic [MAP_AW-1:0]   col_map_addr_o,
  output logic [DATA_W-1:0]   ch_map_data_o,
  output logic [DATA_W-1:0]   col_map_data_o,
  output logic [STRB_W-1:0]   ch_map_wen_o,
  output logic [STRB_W-1:0]   col_map_wen_o,
  input  logic [DATA_W-1:0]   ch_map_data_i,
  input  logic [DATA_W-1:0]   col_map_data_i
);

  state_e              state_q, state_d;
  logic [1:0]          region_q;
  logic [MAP_AW-1:0]   idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic [DATA_W-1:0]   prdata_q;

  logic [1:0]          dec_region;
  logic                dec_region_valid;
  logic [IDX_W-1:0]    dec_idx;
  logic                dec_in_range;
  logic                setup;
  logic [MAP_AW-1:0]   map_addr;
  logic [STRB_W-1:0]   wen;

  apb_vgachargen_decode #(
    .CH_WORDS(CH_WORDS)
  ) u_decode (
    .paddr_i       (paddr_i),
    .region_o      (dec_region),
    .region_valid_o(dec_region_valid),
    .index_o       (dec_idx),
    .in_range_o    (dec_in_range)
  );

  assign setup = (state_q == IDLE) && psel_i && !penable_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          if (!dec_region_valid || !dec_in_range) state_d = ERR;
          else if (pwrite_i)                      state_d = WR;
          else                                    state_d = RD_WAIT;
        end
      end
      RD_WAIT: state_d = psel_i ? RD_DONE : IDLE;
      WR, RD_DONE, ERR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      region_q <= CH_REGION;
      idx_q    <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      prdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (setup) begin
        region_q <= dec_region;
        idx_q    <= MAP_AW'(dec_idx);
        wdata_q  <= pwdata_i;
        strb_q   <= pstrb_i;
        // Errored transfers return zero and leave it as the held read value.
        if (state_d == ERR) prdata_q <= '0;
      end
      if (state_q == RD_WAIT && psel_i)
        prdata_q <= (region_q == COL_REGION) ? col_map_data_i : ch_map_data_i;
    end
  end

  // Map address leads the state machine by a cycle so read data is ready in RD_WAIT.
  assign map_addr       = setup ? MAP_AW'(dec_idx) : idx_q;
  assign ch_map_addr_o  = map_addr;
  assign col_map_addr_o = map_addr;
  assign ch_map_data_o  = wdata_q;
  assign col_map_data_o = wdata_q;

  assign wen           = (state_q == WR && psel_i) ? strb_q : '0;
  assign ch_map_wen_o  = (region_q == CH_REGION)  ? wen : '0;
  assign col_map_wen_o = (region_q == COL_REGION) ? wen : '0;

  assign pready_o = psel_i && ((state_q == WR) || (state_q == RD_DONE) || (state_q == ERR));
  assign prdata_o = prdata_q;

`ifdef APB_VGACHARGEN_PSLVERR_EN
  assign pslverr_o = psel_i && (state_q == ERR);
`else
  assign pslverr_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_vgachargen_slave.sv
// Scoreboard bench for apb_vgachargen_slave: directed APB transfers against a behavioural map RAM.
module tb_apb_vgachargen_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata_o;
  logic        pready_o, pslverr_o;
  logic [9:0]  ch_map_addr_o, col_map_addr_o;
  logic [31:0] ch_map_data_o, col_map_data_o;
  logic [3:0]  ch_map_wen_o, col_map_wen_o;
  logic [31:0] ch_rd, col_rd;
  logic        mem_load;

  logic [31:0] ch_mem  [0:1023];
  logic [31:0] col_mem [0:1023];

`ifdef APB_VGACHARGEN_PSLVERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  typedef struct {
    logic        rd;
    logic        err;
    logic [31:0] data;
    int          waits;
  } cpl_t;

  typedef struct {
    logic        col;
    logic [3:0]  wen;
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  cpl_t cpl_q[$];
  wr_t  wr_q[$];
  int   checks = 0;
  int   errors = 0;
  int   wait_cnt = 0;

  apb_vgachargen_slave dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .paddr_i       (paddr),
    .psel_i        (psel),
    .penable_i     (penable),
    .pwrite_i      (pwrite),
    .pwdata_i      (pwdata),
    .pstrb_i       (pstrb),
    .prdata_o      (prdata_o),
    .pready_o      (pready_o),
    .pslverr_o     (pslverr_o),
    .ch_map_addr_o (ch_map_addr_o),
    .col_map_addr_o(col_map_addr_o),
    .ch_map_data_o (ch_map_data_o),
    .col_map_data_o(col_map_data_o),
    .ch_map_wen_o  (ch_map_wen_o),
    .col_map_wen_o (col_map_wen_o),
    .ch_map_data_i (ch_rd),
    .col_map_data_i(col_rd)
  );

  always #5 clk = ~clk;

  // Synchronous-read map RAM with byte write enables.
  always @(posedge clk) begin
    if (mem_load) begin
      ch_mem[0]  <= 32'h11223344;
      ch_mem[1]  <= 32'h0;
      col_mem[2] <= 32'h0000F00F;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (ch_map_wen_o[b])  ch_mem[ch_map_addr_o][8*b +: 8]   <= ch_map_data_o[8*b +: 8];
        if (col_map_wen_o[b]) col_mem[col_map_addr_o][8*b +: 8] <= col_map_data_o[8*b +: 8];
      end
    end
    ch_rd  <= ch_mem[ch_map_addr_o];
    col_rd <= col_mem[col_map_addr_o];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT completes a transfer or writes a map.
  always @(negedge clk) begin
    if (rst) begin
      wait_cnt = 0;
    end else begin
      if (pready_o) begin
        if (cpl_q.size() == 0) begin
          chk("spurious_pready", 32'(pready_o), 32'd0);
        end else begin
          cpl_t e;
          e = cpl_q.pop_front();
          chk("pslverr", 32'(pslverr_o), 32'(e.err));
          chk("wait_states", 32'(wait_cnt), 32'(e.waits));
          if (e.rd || e.err) chk("prdata", prdata_o, e.data);
        end
        wait_cnt = 0;
      end else if (psel && penable) begin
        wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
      if ((ch_map_wen_o | col_map_wen_o) != 4'h0) begin
        if (wr_q.size() == 0) begin
          chk("spurious_wen", {24'd0, ch_map_wen_o, col_map_wen_o}, 32'd0);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("ch_wen",  32'(ch_map_wen_o),  w.col ? 32'd0 : 32'(w.wen));
          chk("col_wen", 32'(col_map_wen_o), w.col ? 32'(w.wen) : 32'd0);
          chk("wr_addr", 32'(w.col ? col_map_addr_o : ch_map_addr_o), 32'(w.addr));
          chk("wr_data", w.col ? col_map_data_o : ch_map_data_o, w.data);
        end
      end
    end
  end

  task automatic push_cpl(input logic rd, input logic err, input logic [31:0] d, input int waits);
    cpl_t e;
    e.rd = rd; e.err = err; e.data = d; e.waits = waits;
    cpl_q.push_back(e);
  endtask

  task automatic push_wr(input logic col, input logic [3:0] wen, input logic [9:0] a, input logic [31:0] d);
    wr_t w;
    w.col = col; w.wen = wen; w.addr = a; w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic apb_xfer(input logic wr, input logic [13:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [9:0] idx;
    int n;
    idx = a[11:2];
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    #1;
    chk("setup_ch_addr",  32'(ch_map_addr_o),  32'(idx));
    chk("setup_col_addr", 32'(col_map_addr_o), 32'(idx));
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (pready_o) break;
      n++;
      if (n > 8) begin
        checks++; errors++;
        $display("FAIL pready_timeout: got no pready after %0d cycles expected completion", n);
        break;
      end
    end
  endtask

  task automatic apb_idle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_load = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready",  32'(pready_o),  32'd0);
    chk("rst_pslverr", 32'(pslverr_o), 32'd0);
    chk("rst_prdata",  prdata_o,       32'd0);
    chk("rst_wen",     {24'd0, ch_map_wen_o, col_map_wen_o}, 32'd0);
    chk("rst_addr",    {12'd0, ch_map_addr_o, col_map_addr_o}, 32'd0);
    chk("rst_wdata",   ch_map_data_o | col_map_data_o, 32'd0);
    rst = 1'b0; mem_load = 1'b0;

    // Back-to-back directed transfers.
    push_wr(1'b0, 4'hF, 10'd1, 32'h41424344); push_cpl(1'b0, 1'b0, 32'h0, 0);
    apb_xfer(1'b1, 14'h0004, 32'h41424344, 4'hF);
    push_cpl(1'b1, 1'b0, 32'h0000F00F, 1);
    apb_xfer(1'b0, 14'h1008, 32'h0, 4'h0);
    push_cpl(1'b0, ERR_EXP, 32'h0, 0);
    apb_xfer(1'b1, 14'h0960, 32'hDEADDEAD, 4'hF);
    push_cpl(1'b0, ERR_EXP, 32'h0, 0);
    apb_xfer(1'b1, 14'h2000, 32'hDEADDEAD, 4'hF);
    push_cpl(1'b1, ERR_EXP, 32'h0, 0);
    apb_xfer(1'b0, 14'h3004, 32'h0, 4'h0);
    push_wr(1'b0, 4'b0010, 10'd0, 32'hAABBCCDD); push_cpl(1'b0, 1'b0, 32'h0, 0);
    apb_xfer(1'b1, 14'h0000, 32'hAABBCCDD, 4'b0010);
    push_cpl(1'b1, 1'b0, 32'h1122CC44, 1);
    apb_xfer(1'b0, 14'h0000, 32'h0, 4'h0);
    push_cpl(1'b1, 1'b0, 32'h41424344, 1);
    apb_xfer(1'b0, 14'h0004, 32'h0, 4'h0);
    push_wr(1'b1, 4'hF, 10'd599, 32'hDEADBEEF); push_cpl(1'b0, 1'b0, 32'h0, 0);
    apb_xfer(1'b1, 14'h195C, 32'hDEADBEEF, 4'hF);
    push_cpl(1'b1, ERR_EXP, 32'h0, 0);
    apb_xfer(1'b0, 14'h1FFC, 32'h0, 4'h0);
    apb_idle();

    // Abandon a read by dropping psel in its wait state.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 14'h0004;
    @(posedge clk); #1;
    penable = 1'b1;
    #2;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("drop_pready", 32'(pready_o), 32'd0);
    @(negedge clk);
    chk("drop_pready_idle", 32'(pready_o), 32'd0);
    push_wr(1'b1, 4'hF, 10'd4, 32'hCAFE0001); push_cpl(1'b0, 1'b0, 32'h0, 0);
    apb_xfer(1'b1, 14'h1010, 32'hCAFE0001, 4'hF);
    push_cpl(1'b1, 1'b0, 32'hCAFE0001, 1);
    apb_xfer(1'b0, 14'h1010, 32'h0, 4'h0);
    apb_idle();

    // Asynchronous reset in the middle of a read wait state.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 14'h1008;
    @(posedge clk); #1;
    penable = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_pready",  32'(pready_o),  32'd0);
    chk("mid_rst_prdata",  prdata_o,       32'd0);
    chk("mid_rst_pslverr", 32'(pslverr_o), 32'd0);
    chk("mid_rst_wen",     {24'd0, ch_map_wen_o, col_map_wen_o}, 32'd0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    push_wr(1'b0, 4'hF, 10'd2, 32'h01020304); push_cpl(1'b0, 1'b0, 32'h0, 0);
    apb_xfer(1'b1, 14'h0008, 32'h01020304, 4'hF);
    push_cpl(1'b1, 1'b0, 32'h01020304, 1);
    apb_xfer(1'b0, 14'h0008, 32'h0, 4'h0);
    apb_idle();

    repeat (4) @(posedge clk);
    #1;
    chk("cpl_queue_drained", 32'(cpl_q.size()), 32'd0);
    chk("wr_queue_drained",  32'(wr_q.size()),  32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_vgachargen_slave.md
# apb_vgachargen_slave

APB3 completer that gives a bus initiator write and read access to the text-mode character map and colour map of the VGA character generator. It sits between the system APB fabric and the map ports of the character generator top. It turns each APB transfer into a word-wide write-enable or synchronous-read access on the selected map, then completes the transfer with PREADY/PSLVERR.

## Interface
Parameters:
- CH_WORDS, 600, character-map depth in 32-bit words (80×30 chars, 4 per word)
- MAP_AW, 10, map word-address width; must satisfy 2**MAP_AW >= CH_WORDS

Ports:
- clk_i  in  1  single clock; all logic is synchronous to it
- rst_i  in  1  asynchronous, active-high reset
- paddr_i  in  14  APB byte address
- psel_i / penable_i / pwrite_i  in  1  APB control
- pwdata_i  in  32  write data
- pstrb_i  in  4  byte strobes
- prdata_o  out  32  read data
- pready_o / pslverr_o  out  1  APB completion and error
- ch_map_addr_o / col_map_addr_o  out  MAP_AW  map word address
- ch_map_data_o / col_map_data_o  out  32  map write data
- ch_map_wen_o / col_map_wen_o  out  4  per-byte write enable; one-cycle pulse
- ch_map_data_i / col_map_data_i  in  32  map read data, valid one cycle after the address is presented

## Operation
- Address map, decoded from paddr_i[13:12]:
  - 0: character map
  - 1: colour map
  - 2, 3: unmapped
- Word index is paddr_i[11:2]; an index >= CH_WORDS is out of range.
- FSM states: IDLE, WR, RD_WAIT, RD_DONE, ERR.
- IDLE, when psel_i=1 and penable_i=0 (setup phase):
  - Latch region, index, write data and strobes.
  - Drive the map address combinationally from paddr_i.
  - Next state: ERR if unmapped or out of range; otherwise WR if pwrite_i=1, else RD_WAIT.
- WR: selected map wen = pstrb_i for exactly one cycle, with pready_o=1. Return to IDLE.
- RD_WAIT: pready_o=0. Register the selected map read data into prdata_o. Go to RD_DONE.
- RD_DONE: pready_o=1 and prdata_o holds the registered data. Return to IDLE.
- ERR: pready_o=1 and no map write occurs. prdata_o=0. pslverr_o is set per Configuration. Return to IDLE.
- In any non-IDLE state, if psel_i falls: return to IDLE, issue no write, drive pready_o=0.
- Only the selected map's wen is asserted. The other map's wen stays 0.
- Both map address buses carry the same index. Both write-data buses carry pwdata_i.
- prdata_o holds its last value outside RD_DONE and ERR.

## Timing
- Reset values: FSM=IDLE; pready_o=0, pslverr_o=0, prdata_o=0, all wen=0, map addresses=0, map write data=0.
- Reset asserted mid-transfer: outputs go to the reset values immediately (asynchronous). The transfer is abandoned and no partial write is issued.
- Write: 0 wait states. PREADY is high in the first access cycle; wen pulses in that same cycle.
- Read: 1 wait state. The map address is presented in the setup cycle. PREADY is high in the second access cycle.
- Error: 0 wait states.
- Back-to-back transfers: a setup phase in the cycle after PREADY is accepted, with no idle gap.

## Configuration
- APB_VGACHARGEN_PSLVERR_EN defined: unmapped or out-of-range accesses complete with pslverr_o=1.
- APB_VGACHARGEN_PSLVERR_EN undefined: pslverr_o is tied to 0. Erroneous writes are silently dropped and erroneous reads return 0, with the same timing.

## Structure
- vgachargen_pkg holds:
  - the FSM state enum
  - the region codes CH_REGION=2'd0 and COL_REGION=2'd1
  - the CH_WORDS default
  - the map address and data width constants
- One sub-module, apb_vgachargen_decode. It is combinational: paddr → {region valid, index, in-range}.

## Test plan
- Reset: assert rst_i -> pready_o=0, prdata_o=0, both wen=0.
- Write 0x41424344 to 0x0004, pstrb=4'hF -> ch_map_wen_o=4'hF for one cycle with ch_map_addr_o=1; col_map_wen_o stays 0; pready high in the first access cycle.
- Read 0x1008 with col_map_data_i=0x0000F00F -> one wait state, then prdata_o=0x0000F00F with pready_o=1; col_map_addr_o=2.
- Write to 0x0960 (index 600) and to 0x2000 -> with the macro, pslverr_o=1 and no wen; without it, pslverr_o=0 and no wen.
- Byte write to 0x0000 with pstrb=4'b0010 -> ch_map_wen_o=4'b0010 only.
- Drop psel_i during RD_WAIT, and in a separate run assert rst_i during RD_WAIT -> FSM returns to IDLE, pready_o stays 0, no spurious completion; a following back-to-back write then read completes normally.
